sdram_read_sequencer: RTL and testbench
=======================================

Name: sdram_read_sequencer

Overview:
- Upstream control stage for the SDRAM read engine (module `sdram_read`).
- Accepts a burst request (start address, 32-bit word count) from the wishbone SDRAM slave. Drives the engine's `en`/`read_address` and counts the engine's FIFO writes to decide when the burst is complete.
- Owns the periodic refresh timer and emits the one-cycle `auto_rfrsh` pulse consumed by the read engine.
- Flags refreshes that fall due while no read is active, so the top-level controller can service them.

Parameters:
- REFRESH_INTERVAL, 1560, clk cycles between refresh pulses (15.6 us at 100 MHz).
- STOP_MARGIN, 1, words still outstanding at which rd_en is dropped, to cover engine look-ahead.
- COUNT_WIDTH, 24, width of the word count and remaining counters.

Ports:
- clk  in  1  SDRAM clock
- rst  in  1  reset, synchronous, active-high
- req_start  in  1  one-cycle pulse, accepted only while busy=0
- req_address  in  22  start address {bank[21:20], row[19:8], column[7:0]}
- req_count  in  COUNT_WIDTH  number of 32-bit words to read
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse
- words_remaining  out  COUNT_WIDTH  words not yet written to the FIFO
- extra_words  out  8  words written beyond req_count in the last burst (saturates at 255)
- rd_en  out  1  to engine en
- rd_address  out  22  to engine read_address
- rd_ready  in  1  engine ready (delay==0)
- rd_fifo_wr  in  1  engine fifo_wr strobe
- auto_rfrsh  out  1  one-cycle refresh pulse to engine
- idle_rfrsh_req  out  1  refresh due while rd_en low; held until acknowledged
- idle_rfrsh_ack  in  1  clears idle_rfrsh_req

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; refresh timer loaded with REFRESH_INTERVAL-1.
- All outputs are registered.
- States: IDLE, WAIT_READY, STREAM, DRAIN, DONE.
- IDLE:
  - On req_start with req_count!=0: latch base=req_address; set remaining=req_count and words_done=0; clear extra_words; set busy=1; go to WAIT_READY.
  - On req_start with req_count==0: done=1 on the next cycle; busy stays 0; state stays IDLE.
  - req_start while busy=1 is ignored.
- WAIT_READY: when rd_ready=1, set rd_en=1 and go to STREAM. First rd_en is high 2 cycles after req_start at the earliest.
- STREAM:
  - Each rd_fifo_wr decrements remaining and increments words_done.
  - When the post-decrement remaining <= STOP_MARGIN, clear rd_en on that edge and go to DRAIN.
  - If req_count <= STOP_MARGIN, rd_en is high for exactly one cycle; the engine latches it.
- rd_address is always base + words_done (22-bit wrap from 0x3FFFFF to 0x000000). This makes an engine restart after FIFO-full or refresh resume at the correct address.
- DRAIN:
  - rd_fifo_wr continues to decrement remaining.
  - Once remaining is 0, further strobes increment extra_words instead.
  - Exit to DONE when rd_en=0, rd_ready=1 and no rd_fifo_wr has occurred for 4 consecutive cycles (engine idle).
- DONE: done=1 for one cycle, busy=0, go to IDLE. extra_words holds until the next accepted req_start.
- Refresh timer:
  - Free-running down-counter, independent of state.
  - On reaching 0: auto_rfrsh=1 for one cycle and reload.
  - If rd_en=0 on that cycle: also set idle_rfrsh_req=1.
  - idle_rfrsh_ack clears idle_rfrsh_req. If ack and a new due event occur in the same cycle, the set wins.
- Simultaneous rd_fifo_wr and a STREAM→DRAIN transition: the strobe is counted exactly once.
- remaining never underflows; it saturates at 0.
- rst mid-burst: everything returns to reset values on the next edge; no done pulse.

Decomposition:
- Shared package / `sdram_include.v`: state encodings, REFRESH_INTERVAL default, address field positions (bank 21:20, row 19:8, column 7:0).
- One sub-module, `sdram_refresh_timer`: counter, pulse output and idle request/ack latch. It is reused later by the write path.

Test Plan:
- Reset, then idle for 1560 cycles with rd_en=0 → auto_rfrsh pulses once; idle_rfrsh_req=1 until ack; all other outputs 0.
- req_address=0x000010, req_count=4; engine model writes 1 word every 2 cycles → rd_address steps 0x10→0x14; rd_en drops after the 3rd write; words_remaining=0; done pulses once; extra_words=0.
- req_count=4 with the model emitting one extra word after rd_en falls → extra_words=1; done still pulses exactly once.
- req_address=0x3FFFFE, req_count=3 → rd_address sequence 0x3FFFFE, 0x3FFFFF, 0x000000.
- Refresh due during STREAM → auto_rfrsh pulse; idle_rfrsh_req stays 0; model pauses 10 cycles then resumes; rd_address unchanged across the pause.
- req_count=0 → done one cycle later, busy never set. Assert rst mid-burst → outputs 0 and no done pulse.

Source files
------------

// File: rtl/sdram_read_sequencer_pkg.sv
// Shared definitions for the SDRAM read sequencer and its refresh timer.
// Holds the FSM state encoding, address field layout, refresh default and
// the engine-idle detection length.
package sdram_read_sequencer_pkg;

    localparam int unsigned BANK_WIDTH = 2;
    localparam int unsigned ROW_WIDTH  = 12;
    localparam int unsigned COL_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

    localparam int unsigned REFRESH_INTERVAL_DEFAULT = 1560;
    localparam int unsigned EXTRA_WIDTH              = 8;
    localparam int unsigned QUIET_CYCLES             = 4;
    localparam int unsigned QUIET_WIDTH              = $clog2(QUIET_CYCLES + 1);

    // Address layout: bank[21:20], row[19:8], column[7:0].
    typedef struct packed {
        logic [BANK_WIDTH-1:0] bank;
        logic [ROW_WIDTH-1:0]  row;
        logic [COL_WIDTH-1:0]  col;
    } sdram_addr_s;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_STREAM     = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } seq_state_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh timer: one-cycle pulse every INTERVAL cycles, plus a
// sticky request raised when the pulse lands while the read path is inactive.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   active     read path currently enabled (suppresses the idle request)
//   ack        clears idle_req (a coincident new due event wins)
//   pulse      one-cycle refresh pulse
//   idle_req   refresh fell due while inactive; held until ack
module sdram_refresh_timer
    import sdram_read_sequencer_pkg::*;
#(
    parameter int unsigned INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic pulse,
    output logic idle_req
);

    localparam int unsigned CNT_WIDTH = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(INTERVAL - 1);

    logic [CNT_WIDTH-1:0] count;
    logic                 due_c;

    assign due_c = (count == '0);

    // Down-counter with reload; set has priority over ack on the request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= RELOAD;
            pulse    <= 1'b0;
            idle_req <= 1'b0;
        end else begin
            pulse <= due_c;
            count <= due_c ? RELOAD : count - 1'b1;
            if (due_c && !active) begin
                idle_req <= 1'b1;
            end else if (ack) begin
                idle_req <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_read_sequencer.sv
// Upstream control for the SDRAM read engine: accepts a burst request, drives
// the engine enable/address, counts FIFO writes to detect burst completion and
// hosts the periodic refresh timer.
// Ports:
//   req_start/req_address/req_count   burst request from the wishbone slave
//   busy, done, words_remaining, extra_words   burst status
//   rd_en, rd_address, rd_ready, rd_fifo_wr    read engine handshake
//   auto_rfrsh, idle_rfrsh_req, idle_rfrsh_ack refresh signalling
module sdram_read_sequencer
    import sdram_read_sequencer_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
    parameter int unsigned STOP_MARGIN      = 1,
    parameter int unsigned COUNT_WIDTH      = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_start,
    input  logic [ADDR_WIDTH-1:0]  req_address,
    input  logic [COUNT_WIDTH-1:0] req_count,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_remaining,
    output logic [EXTRA_WIDTH-1:0] extra_words,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_address,
    input  logic                   rd_ready,
    input  logic                   rd_fifo_wr,
    output logic                   auto_rfrsh,
    output logic                   idle_rfrsh_req,
    input  logic                   idle_rfrsh_ack
);

    seq_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0] words_done_q, words_done_d;
    logic [EXTRA_WIDTH-1:0] extra_q, extra_d;
    logic [QUIET_WIDTH-1:0] quiet_q, quiet_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]  rd_address_q, rd_address_d;

    logic [COUNT_WIDTH-1:0] remaining_dec_c;
    logic [COUNT_WIDTH-1:0] remaining_after_wr_c;
    logic [QUIET_WIDTH-1:0] quiet_inc_c;
    logic                   stop_c;
    logic                   engine_idle_c;

    // Saturating decrement; the stop decision uses the post-strobe count.
    assign remaining_dec_c      = (remaining_q != '0) ? remaining_q - 1'b1 : '0;
    assign remaining_after_wr_c = rd_fifo_wr ? remaining_dec_c : remaining_q;
    assign stop_c               = (remaining_after_wr_c <= COUNT_WIDTH'(STOP_MARGIN));

    // Consecutive strobe-free cycles including the current one, saturating.
    assign quiet_inc_c   = rd_fifo_wr ? '0
                         : (quiet_q >= QUIET_WIDTH'(QUIET_CYCLES)) ? quiet_q
                         : quiet_q + 1'b1;
    assign engine_idle_c = !rd_en_q && rd_ready && (quiet_inc_c >= QUIET_WIDTH'(QUIET_CYCLES));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (req_start && (req_count != '0)) state_d = ST_WAIT_READY;
            ST_WAIT_READY: if (rd_ready) state_d = ST_STREAM;
            ST_STREAM:     if (stop_c) state_d = ST_DRAIN;
            ST_DRAIN:      if (engine_idle_c) state_d = ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Next values of all registered outputs and burst counters.
    always_comb begin
        base_d       = base_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        extra_d      = extra_q;
        quiet_d      = quiet_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_en_d      = rd_en_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_start) begin
                    extra_d = '0;
                    if (req_count != '0) begin
                        base_d       = req_address;
                        remaining_d  = req_count;
                        words_done_d = '0;
                        busy_d       = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_WAIT_READY: begin
                if (rd_ready) rd_en_d = 1'b1;
            end
            ST_STREAM: begin
                quiet_d = '0;
                if (rd_fifo_wr) begin
                    remaining_d  = remaining_dec_c;
                    words_done_d = words_done_q + 1'b1;
                end
                if (stop_c) rd_en_d = 1'b0;
            end
            ST_DRAIN: begin
                quiet_d = quiet_inc_c;
                if (rd_fifo_wr) begin
                    if (remaining_q != '0) begin
                        remaining_d  = remaining_dec_c;
                        words_done_d = words_done_q + 1'b1;
                    end else if (extra_q != '1) begin
                        extra_d = extra_q + 1'b1;
                    end
                end
                if (engine_idle_c) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase

        // Address tracks progress so an engine restart resumes at the next word.
        rd_address_d = base_d + ADDR_WIDTH'(words_done_d);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            extra_q      <= '0;
            quiet_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_address_q <= '0;
        end else begin
            base_q       <= base_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            extra_q      <= extra_d;
            quiet_q      <= quiet_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            rd_address_q <= rd_address_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign words_remaining = remaining_q;
    assign extra_words     = extra_q;
    assign rd_en           = rd_en_q;
    assign rd_address      = rd_address_q;

    sdram_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk      (clk),
        .rst      (rst),
        .active   (rd_en_q),
        .ack      (idle_rfrsh_ack),
        .pulse    (auto_rfrsh),
        .idle_req (idle_rfrsh_req)
    );

endmodule

// File: tb/tb_sdram_read_sequencer.sv
// Directed bench for sdram_read_sequencer with a simple engine model and an
// expected-address scoreboard filled when each burst request is issued.
module tb_sdram_read_sequencer;

    localparam int REFRESH = 1560;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_start;
    logic [21:0] req_address;
    logic [23:0] req_count;
    logic        busy;
    logic        done;
    logic [23:0] words_remaining;
    logic [7:0]  extra_words;
    logic        rd_en;
    logic [21:0] rd_address;
    logic        rd_ready;
    logic        rd_fifo_wr;
    logic        auto_rfrsh;
    logic        idle_rfrsh_req;
    logic        idle_rfrsh_ack;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_pulses = 0;
    bit rf_while_en = 0;
    bit req_seen = 0;
    logic [21:0] exp_q[$];

    sdram_read_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .req_start       (req_start),
        .req_address     (req_address),
        .req_count       (req_count),
        .busy            (busy),
        .done            (done),
        .words_remaining (words_remaining),
        .extra_words     (extra_words),
        .rd_en           (rd_en),
        .rd_address      (rd_address),
        .rd_ready        (rd_ready),
        .rd_fifo_wr      (rd_fifo_wr),
        .auto_rfrsh      (auto_rfrsh),
        .idle_rfrsh_req  (idle_rfrsh_req),
        .idle_rfrsh_ack  (idle_rfrsh_ack)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; refresh pulse is expected on every multiple.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("auto_rfrsh", 32'(auto_rfrsh), 32'((cyc != 0) && (cyc % REFRESH == 0)));
        if (done === 1'b1) done_pulses++;
        if (auto_rfrsh === 1'b1 && rd_en === 1'b1) rf_while_en = 1;
        if (idle_rfrsh_req === 1'b1) req_seen = 1;
    endtask

    // Issue one burst and act as the engine: one word every 2 cycles once
    // rd_en is seen, count+extra words total, optional 10-cycle pause.
    task automatic run_burst(input logic [21:0] addr, input int count, input int extra,
                             input int pause_at);
        int  written = 0;
        int  cycles = 0;
        bit  en_seen = 0;
        bit  en_dropped = 0;
        bit  paused = 0;
        bit  phase = 0;
        logic [21:0] e;
        for (int i = 0; i < count; i++) begin
            e = addr + 22'(i);
            exp_q.push_back(e);
        end
        done_pulses = 0;
        req_address = addr;
        req_count   = 24'(count);
        req_start   = 1'b1;
        step();
        req_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("remaining_after_start", 32'(words_remaining), 32'(count));
        while (done_pulses == 0 && cycles < 500) begin
            rd_fifo_wr = 1'b0;
            if (rd_en === 1'b1) begin
                en_seen = 1;
            end else if (en_seen && !en_dropped) begin
                en_dropped = 1;
                chk("rd_en_drop_point", 32'(written), 32'(count - 1));
            end
            if (en_seen && written < count + extra) begin
                if (written == pause_at && !paused) begin
                    paused = 1;
                    for (int k = 0; k < 10; k++) begin
                        chk("pause_rd_address", 32'(rd_address), 32'(exp_q[0]));
                        step();
                        cycles++;
                    end
                end else if (phase) begin
                    if (written < count) begin
                        e = exp_q.pop_front();
                        chk("rd_address", 32'(rd_address), 32'(e));
                    end
                    rd_fifo_wr = 1'b1;
                    written++;
                    phase = 0;
                end else begin
                    phase = 1;
                end
            end
            step();
            cycles++;
        end
        rd_fifo_wr = 1'b0;
        chk("done_seen", 32'(done_pulses), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("remaining_at_done", 32'(words_remaining), 32'd0);
        chk("extra_words", 32'(extra_words), 32'(extra));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) step();
        chk("done_once", 32'(done_pulses), 32'd1);
        chk("extra_words_hold", 32'(extra_words), 32'(extra));
    endtask

    initial begin
        rst            = 1'b1;
        req_start      = 1'b0;
        req_address    = '0;
        req_count      = '0;
        rd_ready       = 1'b1;
        rd_fifo_wr     = 1'b0;
        idle_rfrsh_ack = 1'b0;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_address", 32'(rd_address), 32'd0);
        chk("rst_remaining", 32'(words_remaining), 32'd0);
        chk("rst_extra", 32'(extra_words), 32'd0);
        chk("rst_idle_req", 32'(idle_rfrsh_req), 32'd0);
        rst = 1'b0;

        // Idle refresh: pulse at cycle 1560 with rd_en low raises the request.
        while (cyc < REFRESH - 1) step();
        chk("idle_req_before_due", 32'(idle_rfrsh_req), 32'd0);
        step();
        chk("idle_req_set", 32'(idle_rfrsh_req), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rd_en", 32'(rd_en), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_rd_address", 32'(rd_address), 32'd0);
        repeat (3) step();
        chk("idle_req_held", 32'(idle_rfrsh_req), 32'd1);
        idle_rfrsh_ack = 1'b1;
        step();
        idle_rfrsh_ack = 1'b0;
        chk("idle_req_acked", 32'(idle_rfrsh_req), 32'd0);

        // Basic 4-word burst, then one with an extra trailing word, then wrap.
        run_burst(22'h000010, 4, 0, -1);
        run_burst(22'h000200, 4, 1, -1);
        run_burst(22'h3FFFFE, 3, 0, -1);

        // Zero-length request: done next cycle, never busy.
        done_pulses = 0;
        req_count   = '0;
        req_start   = 1'b1;
        step();
        req_start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        step();
        chk("zero_done_clear", 32'(done), 32'd0);
        chk("zero_busy_after", 32'(busy), 32'd0);

        // Refresh during a stream with an engine pause across the pulse.
        while (cyc < 2 * REFRESH - 20) step();
        rf_while_en = 0;
        req_seen    = 0;
        run_burst(22'h001000, 30, 0, 5);
        chk("rfrsh_during_stream", 32'(rf_while_en), 32'd1);
        chk("no_idle_req_in_stream", 32'(req_seen), 32'd0);

        // Reset in the middle of a burst.
        done_pulses = 0;
        req_address = 22'h000100;
        req_count   = 24'd20;
        req_start   = 1'b1;
        step();
        req_start = 1'b0;
        repeat (2) step();
        chk("mid_rd_en", 32'(rd_en), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
        chk("mid_rst_rd_address", 32'(rd_address), 32'd0);
        chk("mid_rst_remaining", 32'(words_remaining), 32'd0);
        chk("mid_rst_extra", 32'(extra_words), 32'd0);
        chk("mid_rst_idle_req", 32'(idle_rfrsh_req), 32'd0);
        rst = 1'b0;
        repeat (10) step();
        chk("mid_rst_no_done", 32'(done_pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
